// File: rtl/uart_tx_arb.sv
// Message-granular round-robin arbiter feeding one uart_tx_fifo from N_REQ byte streams.
// A grant is held until the last byte (or MAX_LEN bytes); an optional channel-ID header leads.
module uart_tx_arb #(
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      N_REQ    = 4,
   parameter bit               HDR_EN   = 1'b1,
   parameter logic [WIDTH-1:0] HDR_BASE = 8'hF0,
   parameter int unsigned      MAX_LEN  = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_last,
   output logic [N_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]       out_din,
   output logic                   out_req,
   input  logic                   out_ready,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy,
   output logic                   msg_trunc
);

   localparam int unsigned GW = $clog2(N_REQ);

   typedef enum logic [1:0] {StIdle = 2'd0, StHdr = 2'd1, StData = 2'd2} state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   gid_q, gid_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]     beat_cnt_q, beat_cnt_d;
   logic            trunc_q, trunc_d;

   logic [GW-1:0]    pick, scan_idx, next_ptr;
   logic [N_REQ-1:0] gid_onehot;
   logic [WIDTH-1:0] sel_data;
   logic             sel_valid, sel_last, msg_end;

   // Scan from rr_ptr upward; iterating backwards lets the nearest valid requester win.
   always_comb begin
      pick     = rr_ptr_q;
      scan_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_idx = GW'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
         if (req_valid[scan_idx]) pick = scan_idx;
      end
   end

   always_comb begin
      gid_onehot = '0;
      sel_data   = '0;
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (GW'(i) == gid_q) begin
            gid_onehot[i] = 1'b1;
            sel_data      = req_data[i*WIDTH +: WIDTH];
            sel_valid     = req_valid[i];
            sel_last      = req_last[i];
         end
      end
   end

   assign next_ptr = GW'((32'(gid_q) + 32'd1) % N_REQ);

   always_comb begin
      state_d    = state_q;
      gid_d      = gid_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      trunc_d    = 1'b0;
      msg_end    = 1'b0;
      out_din    = '0;
      out_req    = 1'b0;
      req_ready  = '0;
      grant      = '0;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               gid_d   = pick;
               state_d = HDR_EN ? StHdr : StData;
            end
         end
         StHdr: begin
            out_din = HDR_BASE + WIDTH'(gid_q);
            out_req = 1'b1;
            grant   = gid_onehot;
            if (out_ready) state_d = StData;
         end
         StData: begin
            out_din   = sel_data;
            out_req   = sel_valid;
            req_ready = gid_onehot & {N_REQ{out_ready}};
            grant     = gid_onehot;
            if (sel_valid && out_ready) begin
               if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
               if (sel_last) begin
                  msg_end = 1'b1;
               end else if (MAX_LEN != 0 && 32'(beat_cnt_q) + 32'd1 == MAX_LEN) begin
                  msg_end = 1'b1;
                  trunc_d = 1'b1;
               end
            end
            if (msg_end) begin
               state_d    = StIdle;
               rr_ptr_d   = next_ptr;
               beat_cnt_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy      = (state_q != StIdle);
   assign msg_trunc = trunc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         gid_q      <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gid_q      <= gid_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed arbitration table, hand sequences for stalls, truncation and
// reset, then random traffic checked cycle-by-cycle against a message-level reference model.
module tb_uart_tx_arb;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int ML = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_valid, req_last, req_ready, grant;
   logic [W-1:0]     out_din;
   logic             out_req, out_ready, busy, msg_trunc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_arb #(
      .WIDTH    (W),
      .N_REQ    (N),
      .HDR_EN   (1'b1),
      .HDR_BASE (8'hF0),
      .MAX_LEN  (ML)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_din   (out_din),
      .out_req   (out_req),
      .out_ready (out_ready),
      .grant     (grant),
      .busy      (busy),
      .msg_trunc (msg_trunc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner (-1 = none), header pending, bytes sent, round-robin start.
   int          m_owner = -1;
   int          m_ptr   = 0;
   int          m_sent  = 0;
   bit          m_hdr   = 1'b0;
   bit          m_trunc = 1'b0;
   logic [N-1:0] acc_mask = '0;
   logic [7:0]  out_log[$];
   logic [7:0]  exp_log[$];

   task automatic model_step();
      logic [N-1:0] e_grant, e_ready;
      logic         e_req;
      logic [W-1:0] e_din;
      bit           is_last;
      e_grant = '0;
      e_ready = '0;
      e_req   = 1'b0;
      e_din   = '0;
      if (m_owner >= 0) begin
         e_grant[m_owner] = 1'b1;
         if (m_hdr) begin
            e_req = 1'b1;
            e_din = 8'(8'hF0 + m_owner);
         end else begin
            e_req            = req_valid[m_owner];
            e_din            = req_data[m_owner*W +: W];
            e_ready[m_owner] = out_ready;
         end
      end
      check("m_grant", grant, e_grant);
      check("m_busy", busy, (m_owner >= 0));
      check("m_out_req", out_req, e_req);
      check("m_req_ready", req_ready, e_ready);
      check("m_msg_trunc", msg_trunc, m_trunc);
      if (e_req) check("m_out_din", out_din, e_din);
      if (out_req && out_ready) out_log.push_back(out_din);
      acc_mask = req_valid & e_ready;
      m_trunc  = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++)
            if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         if (m_owner >= 0) m_hdr = 1'b1;
      end else if (m_hdr) begin
         if (out_ready) m_hdr = 1'b0;
      end else if (e_req && out_ready) begin
         m_sent++;
         is_last = req_last[m_owner];
         if (is_last || m_sent == ML) begin
            m_trunc = !is_last;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_sent  = 0;
         end
      end
   endtask

   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         m_owner  = -1;
         m_ptr    = 0;
         m_sent   = 0;
         m_hdr    = 1'b0;
         m_trunc  = 1'b0;
         acc_mask = '0;
      end else if (!clk) begin
         model_step();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_byte(input int i, input logic [7:0] d, input bit v, input bit l);
      req_data[i*W +: W] = d;
      req_valid[i]       = v;
      req_last[i]        = l;
   endtask

   task automatic check_log(input string nm);
      check({nm, "_len"}, out_log.size(), exp_log.size());
      for (int k = 0; k < exp_log.size() && k < out_log.size(); k++)
         check(nm, {24'd0, out_log[k]}, {24'd0, exp_log[k]});
   endtask

   typedef struct {
      logic [N-1:0] mask;
      int           gid;
   } arb_vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } ent_t;

   arb_vec_t tbl[8];
   ent_t     srcq[N][$];

   initial begin
      int   k, cyc, left;
      bit   seen;
      ent_t e;

      tbl[0] = '{4'b0101, 0};
      tbl[1] = '{4'b0101, 2};
      tbl[2] = '{4'b0101, 0};
      tbl[3] = '{4'b1000, 3};
      tbl[4] = '{4'b1111, 0};
      tbl[5] = '{4'b1111, 1};
      tbl[6] = '{4'b0010, 1};
      tbl[7] = '{4'b0011, 0};

      req_data  = '0;
      req_valid = '0;
      req_last  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_out_req", out_req, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_msg_trunc", msg_trunc, 0);
      #2 rst = 1'b1;
      tick();

      // Round-robin table: one-byte messages, one idle cycle between grants.
      for (int i = 0; i < 8; i++) begin
         req_valid = tbl[i].mask;
         req_last  = '1;
         for (int j = 0; j < N; j++) req_data[j*W +: W] = 8'(8'h10 + j);
         tick();
         check("tbl_grant", grant, 32'(1) << tbl[i].gid);
         check("tbl_hdr", out_din, 32'(8'hF0 + tbl[i].gid));
         tick();
         check("tbl_data", out_din, 32'(8'h10 + tbl[i].gid));
         check("tbl_ready", req_ready, 32'(1) << tbl[i].gid);
         tick();
         check("tbl_idle", busy, 0);
         req_valid = '0;
         req_last  = '0;
      end

      // Single two-byte message on req0.
      out_log.delete();
      set_byte(0, 8'h41, 1'b1, 1'b0);
      tick();
      check("t1_grant_hdr", grant, 4'b0001);
      tick();
      check("t1_grant_b0", grant, 4'b0001);
      check("t1_din_b0", out_din, 8'h41);
      tick();
      set_byte(0, 8'h42, 1'b1, 1'b1);
      check("t1_grant_b1", grant, 4'b0001);
      tick();
      req_valid = '0;
      check("t1_busy_end", busy, 0);
      check("t1_grant_end", grant, 0);
      exp_log = {8'hF0, 8'h41, 8'h42};
      check_log("t1_log");

      // FIFO full for 5 cycles mid-message.
      out_log.delete();
      set_byte(1, 8'hA1, 1'b1, 1'b0);
      tick();
      tick();
      out_ready = 1'b0;
      repeat (5) begin
         tick();
         check("t4_out_req", out_req, 1);
         check("t4_din_hold", out_din, 8'hA1);
         check("t4_ready_low", req_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      set_byte(1, 8'hA2, 1'b1, 1'b0);
      tick();
      set_byte(1, 8'hA3, 1'b1, 1'b1);
      tick();
      req_valid = '0;
      exp_log = {8'hF1, 8'hA1, 8'hA2, 8'hA3};
      check_log("t4_log");

      // MAX_LEN truncation on an endless req1 stream, then regrant from rr_ptr=2.
      out_log.delete();
      k    = 0;
      cyc  = 0;
      seen = 1'b0;
      set_byte(1, 8'hB0, 1'b1, 1'b0);
      while (!seen && cyc < 30) begin
         tick();
         cyc++;
         if (acc_mask[1]) k++;
         set_byte(1, 8'(8'hB0 + k), 1'b1, 1'b0);
         if (msg_trunc) seen = 1'b1;
      end
      check("t5_trunc_seen", seen, 1);
      check("t5_bytes", k, ML);
      set_byte(2, 8'hC0, 1'b1, 1'b1);
      tick();
      check("t5_regrant", grant, 4'b0100);
      check("t5_hdr2", out_din, 8'hF2);
      check("t5_trunc_pulse", msg_trunc, 0);
      tick();
      tick();
      req_valid = '0;
      exp_log = {8'hF1, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hF2, 8'hC0};
      check_log("t5_log");

      // Asynchronous reset during byte 2 of a req1 message.
      set_byte(1, 8'hD0, 1'b1, 1'b0);
      tick();
      tick();
      tick();
      set_byte(1, 8'hD1, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("t6_out_req", out_req, 0);
      check("t6_grant", grant, 0);
      check("t6_busy", busy, 0);
      check("t6_req_ready", req_ready, 0);
      set_byte(1, 8'hE1, 1'b1, 1'b1);
      set_byte(3, 8'hE3, 1'b1, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      tick();
      check("t6_winner", grant, 4'b0010);
      check("t6_hdr", out_din, 8'hF1);
      tick();
      tick();
      req_valid = '0;
      req_last  = '0;

      // Random traffic: per-requester message queues, random bubbles and back-pressure.
      for (int i = 0; i < N; i++) begin
         for (int m = 0; m < 30; m++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
               e.d = 8'($urandom);
               e.l = (b == len - 1);
               srcq[i].push_back(e);
            end
         end
      end
      cyc = 0;
      left = 1;
      while (left != 0 && cyc < 6000) begin
         for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && $urandom_range(3) != 0) begin
               set_byte(i, srcq[i][0].d, 1'b1, srcq[i][0].l);
            end else begin
               set_byte(i, 8'($urandom), 1'b0, 1'($urandom));
            end
         end
         out_ready = ($urandom_range(3) != 0);
         tick();
         cyc++;
         for (int i = 0; i < N; i++)
            if (acc_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
         left = 0;
         for (int i = 0; i < N; i++) left += srcq[i].size();
      end
      check("rand_drained", left, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
